// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared types and helpers for the data-memory access unit.
// The optional LL/SC link logic in the top is enabled by the macro DMEM_LLSC_EN.
package mips_mem_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} dmem_state_e;

    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} mem_size_e;

    localparam logic [3:0] BE_WORD = 4'hF;

    function automatic mem_size_e size_of(input logic hf, input logic by);
        return by ? SZ_BYTE : hf ? SZ_HALF : SZ_WORD;
    endfunction

endpackage

// File: rtl/dmem_access_unit_if.sv
// dmem_access_unit_if: data-memory req/ack bus; the access unit is master, memory is slave.
interface dmem_access_unit_if;

    logic        req;
    logic        we;
    logic [29:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;

    modport master (output req, we, addr, be, wdata, input rdata, ack);
    modport slave  (input req, we, addr, be, wdata, output rdata, ack);

endinterface

// File: rtl/mem_lane_align.sv
// mem_lane_align: big-endian byte-lane steering, load extension and alignment check.
module mem_lane_align
    import mips_mem_pkg::*;
(
    input  mem_size_e   i_size,
    input  logic [1:0]  i_off,
    input  logic        i_sign,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata,
    output logic        o_misaligned
);

    logic [7:0]  w_rbyte;
    logic [15:0] w_rhalf;

    // offset 0 is the most significant lane, so shift by the distance from the bottom lane
    assign w_rbyte = 8'(i_rdata >> {~i_off, 3'b000});
    assign w_rhalf = 16'(i_rdata >> {~i_off[1], 4'b0000});

    always_comb begin
        o_be         = (i_size == SZ_BYTE) ? 4'b1000 >> i_off :
                       (i_size == SZ_HALF) ? 4'b1100 >> {i_off[1], 1'b0} : BE_WORD;
        o_wdata      = (i_size == SZ_BYTE) ? {4{i_wdata[7:0]}} :
                       (i_size == SZ_HALF) ? {2{i_wdata[15:0]}} : i_wdata;
        o_rdata      = (i_size == SZ_BYTE) ? {{24{i_sign & w_rbyte[7]}}, w_rbyte} :
                       (i_size == SZ_HALF) ? {{16{i_sign & w_rhalf[15]}}, w_rhalf} : i_rdata;
        o_misaligned = ((i_size == SZ_HALF) & i_off[0]) | ((i_size == SZ_WORD) & (|i_off));
    end

endmodule

// File: rtl/dmem_access_unit.sv
// dmem_access_unit: runs one req/ack data-memory transaction per core load/store, stalling the core.
// Define DMEM_LLSC_EN to enable LL/SC link tracking; otherwise LLSC is ignored.
module dmem_access_unit
    import mips_mem_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [31:0]        i_addr,
    input  logic [31:0]        i_wdata,
    input  logic               i_mem_read,
    input  logic               i_mem_write,
    input  logic               i_mem_half,
    input  logic               i_mem_byte,
    input  logic               i_mem_sign_extend,
    input  logic               i_llsc,
    output logic [31:0]        o_rdata,
    output logic               o_stall,
    output logic               o_align_err,
    output logic               o_bus_err,
    dmem_access_unit_if.master bus
);

    dmem_state_e r_state, w_next;
    mem_size_e   r_size, w_size_in, w_size;
    logic [29:0] r_addr;
    logic [1:0]  r_off, w_off;
    logic        r_we, r_sign, r_sc, w_sign;
    logic [31:0] r_wdata, r_rdata, w_wd_in;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]  w_be;
    logic [31:0] w_wdata, w_ext;
    logic        w_mis, w_req, w_ll, w_sc, w_sc_ok, w_sc_fail;
    logic        w_idle, w_busy, w_accept, w_align_err, w_timeout;

    assign w_idle      = r_state == IDLE;
    assign w_busy      = r_state == BUSY;
    assign w_req       = i_mem_read | i_mem_write;
    assign w_sc        = i_llsc & i_mem_write;
    assign w_sc_fail   = w_sc & ~w_sc_ok;
    assign w_size_in   = w_ll ? SZ_WORD : size_of(i_mem_half, i_mem_byte);
    assign w_accept    = ~i_rst & w_idle & w_req & ~w_mis;
    assign w_align_err = ~i_rst & w_idle & w_req & w_mis;
    assign w_timeout   = w_busy & ~bus.ack & (r_cnt == CNT_W'(TIMEOUT - 1));

    // the aligner sees the live request in IDLE and the latched one while the bus cycle runs
    assign w_size  = w_idle ? w_size_in : r_size;
    assign w_off   = w_idle ? i_addr[1:0] : r_off;
    assign w_sign  = w_idle ? i_mem_sign_extend : r_sign;
    assign w_wd_in = w_idle ? i_wdata : r_wdata;

    mem_lane_align u_align (
        .i_size       (w_size),
        .i_off        (w_off),
        .i_sign       (w_sign),
        .i_wdata      (w_wd_in),
        .i_rdata      (bus.rdata),
        .o_be         (w_be),
        .o_wdata      (w_wdata),
        .o_rdata      (w_ext),
        .o_misaligned (w_mis)
    );

`ifdef DMEM_LLSC_EN
    logic        r_link_valid;
    logic [29:0] r_link_addr;

    assign w_ll    = i_llsc & i_mem_read & ~i_mem_write;
    assign w_sc_ok = r_link_valid & (r_link_addr == i_addr[31:2]);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_link_valid <= 1'b0;
            r_link_addr  <= '0;
        end else if (w_accept && w_ll) begin
            r_link_valid <= 1'b1;
            r_link_addr  <= i_addr[31:2];
        end else if (w_timeout || (w_busy && bus.ack && r_we && r_addr == r_link_addr)) begin
            r_link_valid <= 1'b0;
        end
    end
`else
    assign w_ll    = 1'b0;
    assign w_sc_ok = 1'b1;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = w_idle ? (w_accept ? (w_sc_fail ? DONE : BUSY) : IDLE) :
                 w_busy ? ((bus.ack || w_timeout) ? DONE : BUSY) : IDLE;
    end

    always_comb begin
        o_stall     = ~i_rst & (w_busy | w_accept);
        o_align_err = w_align_err;
        o_bus_err   = w_timeout;
        o_rdata     = r_rdata;
        bus.req     = w_busy;
        bus.we      = w_busy & r_we;
        bus.addr    = w_busy ? r_addr : '0;
        bus.be      = w_busy ? w_be : '0;
        bus.wdata   = w_busy ? w_wdata : '0;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_addr  <= '0;
            r_off   <= '0;
            r_size  <= SZ_BYTE;
            r_we    <= 1'b0;
            r_sign  <= 1'b0;
            r_sc    <= 1'b0;
            r_wdata <= '0;
            r_cnt   <= '0;
            r_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_addr  <= i_addr[31:2];
                r_off   <= i_addr[1:0];
                r_size  <= w_size_in;
                r_we    <= i_mem_write;
                r_sign  <= i_mem_sign_extend;
                r_sc    <= w_sc;
                r_wdata <= i_wdata;
            end
            r_cnt <= w_busy ? r_cnt + CNT_W'(1) : '0;
            if (w_align_err || (w_accept && w_sc_fail) || w_timeout)
                r_rdata <= '0;
            else if (w_busy && bus.ack)
                r_rdata <= r_we ? {31'd0, r_sc} : w_ext;
        end
    end

endmodule

// File: tb/tb_dmem_access_unit.sv
// tb_dmem_access_unit: directed checks of the data-memory access unit with TIMEOUT=8.
module tb_dmem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = '0, wdata = '0, rdata_o;
    logic        rd = 0, wr = 0, hf = 0, by = 0, sx = 0, ll = 0;
    logic        stall, aerr, berr;
    int          checks = 0, failures = 0;
    int          n_stall, n_req, n_aerr, n_berr;
    logic [3:0]  s_be;
    logic [29:0] s_addr;
    logic        s_we, s_done;
    logic [31:0] s_wdata;

    dmem_access_unit_if bus_if ();

    dmem_access_unit #(.TIMEOUT(8), .CNT_W(4)) dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_addr            (addr),
        .i_wdata           (wdata),
        .i_mem_read        (rd),
        .i_mem_write       (wr),
        .i_mem_half        (hf),
        .i_mem_byte        (by),
        .i_mem_sign_extend (sx),
        .i_llsc            (ll),
        .o_rdata           (rdata_o),
        .o_stall           (stall),
        .o_align_err       (aerr),
        .o_bus_err         (berr),
        .bus               (bus_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Presents one request and acks on the ack_at-th BUSY cycle (0 = never); returns after Stall drops.
    task automatic run_req(input logic [31:0] a, input logic [31:0] wd, input logic r, input logic w,
                           input logic h, input logic b, input logic s, input logic l,
                           input int ack_at, input logic [31:0] rdat);
        addr = a; wdata = wd; rd = r; wr = w; hf = h; by = b; sx = s; ll = l;
        n_stall = 0; n_req = 0; n_aerr = 0; n_berr = 0; s_done = 0;
        s_be = '0; s_addr = '0; s_we = 0; s_wdata = '0;
        for (int c = 0; c < 40 && !s_done; c++) begin
            bus_if.ack   = bus_if.req && (n_req + 1 == ack_at);
            bus_if.rdata = rdat;
            #1;
            if (bus_if.req) begin
                if (n_req == 0) begin
                    s_be = bus_if.be; s_addr = bus_if.addr; s_we = bus_if.we; s_wdata = bus_if.wdata;
                end
                n_req++;
            end
            n_stall += int'(stall);
            n_aerr  += int'(aerr);
            n_berr  += int'(berr);
            s_done = !stall;
            tick();
            rd = 0; wr = 0; ll = 0; bus_if.ack = 0;
        end
        chk("completed", 32'(s_done), 32'd1);
    endtask

    initial begin
        bus_if.ack = 0;
        bus_if.rdata = '0;
        tick();
        tick();
        chk("rst_stall", 32'(stall), 0);
        chk("rst_req", 32'(bus_if.req), 0);
        chk("rst_rdata", rdata_o, 0);
        chk("rst_be", 32'(bus_if.be), 0);
        addr = 32'h100; rd = 1;
        #1;
        chk("rst_req_stall", 32'(stall), 0);
        rd = 0;
        tick();
        rst = 0;
        tick();

        run_req(32'h100, 0, 1, 0, 0, 0, 0, 0, 3, 32'hDEADBEEF);
        chk("lw_stall_cycles", n_stall, 4);
        chk("lw_req_cycles", n_req, 3);
        chk("lw_be", 32'(s_be), 32'hF);
        chk("lw_addr", 32'(s_addr), 32'h40);
        chk("lw_we", 32'(s_we), 0);
        chk("lw_rdata", rdata_o, 32'hDEADBEEF);

        bus_if.ack = 1; bus_if.rdata = 32'hFFFFFFFF;
        #1;
        chk("idle_ack_stall", 32'(stall), 0);
        tick();
        bus_if.ack = 0;
        chk("idle_ack_rdata", rdata_o, 32'hDEADBEEF);

        run_req(32'h103, 0, 1, 0, 0, 1, 1, 0, 1, 32'h112233F0);
        chk("lb_stall_cycles", n_stall, 2);
        chk("lb_be", 32'(s_be), 32'h1);
        chk("lb_rdata", rdata_o, 32'hFFFFFFF0);

        run_req(32'h103, 0, 1, 0, 0, 1, 0, 0, 1, 32'h112233F0);
        chk("lbu_rdata", rdata_o, 32'h000000F0);

        run_req(32'h102, 0, 1, 0, 0, 0, 0, 0, 1, 32'h0);
        chk("lw_mis_aerr", n_aerr, 1);
        chk("lw_mis_req", n_req, 0);
        chk("lw_mis_stall", n_stall, 0);
        chk("lw_mis_rdata", rdata_o, 0);

        run_req(32'h102, 0, 1, 0, 1, 0, 1, 0, 2, 32'h12348001);
        chk("lh_be", 32'(s_be), 32'h3);
        chk("lh_rdata", rdata_o, 32'hFFFF8001);

        run_req(32'h201, 32'h0000ABCD, 0, 1, 1, 0, 0, 0, 1, 32'h0);
        chk("sh_mis_aerr", n_aerr, 1);
        chk("sh_mis_req", n_req, 0);
        chk("sh_mis_stall", n_stall, 0);
        chk("sh_mis_rdata", rdata_o, 0);

        run_req(32'h100, 0, 1, 0, 1, 0, 0, 0, 1, 32'h80011234);
        chk("lhu_be", 32'(s_be), 32'hC);
        chk("lhu_rdata", rdata_o, 32'h00008001);

        run_req(32'h202, 32'h0000ABCD, 0, 1, 1, 0, 0, 0, 2, 32'h0);
        chk("sh_we", 32'(s_we), 1);
        chk("sh_be", 32'(s_be), 32'h3);
        chk("sh_addr", 32'(s_addr), 32'h80);
        chk("sh_wdata", s_wdata, 32'hABCDABCD);

        run_req(32'h301, 32'h0000005A, 0, 1, 0, 1, 0, 0, 1, 32'h0);
        chk("sb_be", 32'(s_be), 32'h4);
        chk("sb_wdata", s_wdata, 32'h5A5A5A5A);

        run_req(32'h104, 0, 1, 0, 0, 0, 0, 0, 8, 32'h55AA55AA);
        chk("lastack_req", n_req, 8);
        chk("lastack_berr", n_berr, 0);
        chk("lastack_rdata", rdata_o, 32'h55AA55AA);

        run_req(32'h400, 32'h12345678, 0, 1, 0, 0, 0, 0, 0, 32'h0);
        chk("to_req_cycles", n_req, 8);
        chk("to_berr", n_berr, 1);
        chk("to_stall_cycles", n_stall, 9);
        chk("to_rdata", rdata_o, 0);
        chk("to_idle_req", 32'(bus_if.req), 0);

        run_req(32'h100, 0, 1, 0, 0, 0, 0, 0, 1, 32'h0BADF00D);
        chk("pre_rst_rdata", rdata_o, 32'h0BADF00D);
        addr = 32'h100; rd = 1;
        tick();
        rd = 0;
        tick();
        chk("mid_busy_req", 32'(bus_if.req), 1);
        rst = 1;
        #1;
        chk("mid_rst_req", 32'(bus_if.req), 0);
        chk("mid_rst_stall", 32'(stall), 0);
        tick();
        rst = 0;
        tick();
        chk("post_rst_req", 32'(bus_if.req), 0);
        chk("post_rst_rdata", rdata_o, 0);
        run_req(32'h108, 0, 1, 0, 0, 0, 0, 0, 1, 32'h13579BDF);
        chk("post_rst_lw_addr", 32'(s_addr), 32'h42);
        chk("post_rst_lw_rdata", rdata_o, 32'h13579BDF);

        run_req(32'h300, 0, 1, 0, 0, 0, 0, 1, 1, 32'hCAFE0000);
        chk("ll_rdata", rdata_o, 32'hCAFE0000);
`ifdef DMEM_LLSC_EN
        run_req(32'h300, 32'h1, 0, 1, 0, 0, 0, 0, 1, 32'h0);
        run_req(32'h300, 32'h2, 0, 1, 0, 0, 0, 1, 1, 32'h0);
        chk("sc_fail_req", n_req, 0);
        chk("sc_fail_stall", n_stall, 1);
        chk("sc_fail_rdata", rdata_o, 0);
        run_req(32'h300, 0, 1, 0, 0, 0, 0, 1, 1, 32'h0);
`endif
        run_req(32'h300, 32'h3, 0, 1, 0, 0, 0, 1, 1, 32'h0);
        chk("sc_ok_req", n_req, 1);
        chk("sc_ok_we", 32'(s_we), 1);
        chk("sc_ok_rdata", rdata_o, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
